// File: rtl/regfile_pkg.sv
// Shared register-file constants and types for the issue-side scoreboard.
package regfile_pkg;

    localparam int NUM_REGS   = 8;
    localparam int REG_ADDR_W = 3;
    localparam int SB_CNT_W   = 2;

    typedef logic [REG_ADDR_W-1:0] reg_addr_t;

endpackage : regfile_pkg

// File: rtl/sb_entry.sv
// One pending-write counter for a single architectural register.
module sb_entry
    import regfile_pkg::*;
#(
    parameter int CNT_W = SB_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic dec,
    input  logic clr,
    output logic busy,
    output logic full
);

    logic [CNT_W-1:0] cnt;

    // NOTE: sequential state uses non-blocking assignments so every entry
    // samples the same pre-edge values regardless of evaluation order.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !dec) begin
            cnt <= cnt + CNT_W'(1);
        end else if (dec && !inc) begin
            cnt <= cnt - CNT_W'(1);
        end
    end

    assign busy = (cnt != '0);
    assign full = (&cnt);

endmodule : sb_entry

// File: rtl/reg_scoreboard.sv
// Issue-side RAW/saturation scoreboard for the 1W/2R register file.
// Optional stall statistics port enabled by defining REG_SCOREBOARD_STATS_EN.
module reg_scoreboard
    import regfile_pkg::*;
#(
    parameter int NUM_REGS = regfile_pkg::NUM_REGS,
    parameter int CNT_W    = regfile_pkg::SB_CNT_W
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                issue_valid,
    input  reg_addr_t           issue_src1,
    input  reg_addr_t           issue_src2,
    input  logic                issue_src1_used,
    input  logic                issue_src2_used,
    input  reg_addr_t           issue_dst,
    input  logic                issue_dst_used,
    output logic                issue_ready,
    input  logic                wb_valid,
    input  reg_addr_t           wb_addr,
    input  logic                flush,
    output logic [NUM_REGS-1:0] busy_mask,
    output logic                wb_err
`ifdef REG_SCOREBOARD_STATS_EN
    ,
    output logic [15:0]         stall_cnt
`endif
);

    logic [NUM_REGS-1:0] busy;
    logic [NUM_REGS-1:0] full;
    logic [NUM_REGS-1:0] inc;
    logic [NUM_REGS-1:0] dec;
    logic                hazard;
    logic                fire;
    logic                wb_live;

    // Hazard sees only registered counts, so writeback and flush never
    // reach issue_ready combinationally (no same-cycle bypass).
    assign hazard = (issue_src1_used && busy[issue_src1])
                 || (issue_src2_used && busy[issue_src2])
                 || (issue_dst_used  && full[issue_dst]);

    assign issue_ready = !hazard;
    assign fire        = issue_valid && issue_ready && issue_dst_used && !flush;
    assign wb_live     = wb_valid && !flush;
    assign busy_mask   = busy;

    // NOTE: every always_comb output gets a default first so no latch is inferred.
    always_comb begin
        inc = '0;
        dec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc[i] = fire    && (issue_dst == reg_addr_t'(i));
            dec[i] = wb_live && (wb_addr   == reg_addr_t'(i)) && busy[i];
        end
    end

    for (genvar i = 0; i < NUM_REGS; i++) begin : g_entry
        sb_entry #(.CNT_W(CNT_W)) u_entry (
            .clk  (clk),
            .rst  (rst),
            .inc  (inc[i]),
            .dec  (dec[i]),
            .clr  (flush),
            .busy (busy[i]),
            .full (full[i])
        );
    end

    // Writeback to an idle register is a pipeline bug; latch it until reset.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_err <= 1'b0;
        end else if (wb_live && !busy[wb_addr]) begin
            wb_err <= 1'b1;
        end
    end

`ifdef REG_SCOREBOARD_STATS_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_cnt <= '0;
        end else if (issue_valid && !issue_ready && (stall_cnt != 16'hFFFF)) begin
            stall_cnt <= stall_cnt + 16'd1;
        end
    end
`endif

endmodule : reg_scoreboard

// File: tb/tb_reg_scoreboard.sv
// Self-checking bench for reg_scoreboard: vector table plus expected-state scoreboard.
module tb_reg_scoreboard;
    import regfile_pkg::*;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       issue_valid = 1'b0;
    reg_addr_t  issue_src1 = '0;
    reg_addr_t  issue_src2 = '0;
    logic       issue_src1_used = 1'b0;
    logic       issue_src2_used = 1'b0;
    reg_addr_t  issue_dst = '0;
    logic       issue_dst_used = 1'b0;
    logic       issue_ready;
    logic       wb_valid = 1'b0;
    reg_addr_t  wb_addr = '0;
    logic       flush = 1'b0;
    logic [7:0] busy_mask;
    logic       wb_err;
`ifdef REG_SCOREBOARD_STATS_EN
    logic [15:0] stall_cnt;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    reg_scoreboard dut (
        .clk             (clk),
        .rst             (rst),
        .issue_valid     (issue_valid),
        .issue_src1      (issue_src1),
        .issue_src2      (issue_src2),
        .issue_src1_used (issue_src1_used),
        .issue_src2_used (issue_src2_used),
        .issue_dst       (issue_dst),
        .issue_dst_used  (issue_dst_used),
        .issue_ready     (issue_ready),
        .wb_valid        (wb_valid),
        .wb_addr         (wb_addr),
        .flush           (flush),
        .busy_mask       (busy_mask),
        .wb_err          (wb_err)
`ifdef REG_SCOREBOARD_STATS_EN
        ,
        .stall_cnt       (stall_cnt)
`endif
    );

    typedef struct {
        logic       iv;
        reg_addr_t  s1;
        logic       s1u;
        reg_addr_t  s2;
        logic       s2u;
        reg_addr_t  dst;
        logic       du;
        logic       wbv;
        reg_addr_t  wba;
        logic       fl;
        logic       e_rdy;
        logic [7:0] e_busy;
        logic       e_err;
    } vec_t;

    typedef struct {
        int         id;
        logic [7:0] busy;
        logic       err;
    } exp_t;

    vec_t vecs[$];
    exp_t sb_q[$];

    function automatic vec_t mk(logic iv, int s1, logic s1u, int s2, logic s2u,
                                int dst, logic du, logic wbv, int wba, logic fl,
                                logic rdy, logic [7:0] bz, logic er);
        vec_t v;
        v.iv = iv;  v.s1 = 3'(s1);   v.s1u = s1u; v.s2 = 3'(s2); v.s2u = s2u;
        v.dst = 3'(dst); v.du = du;  v.wbv = wbv; v.wba = 3'(wba); v.fl = fl;
        v.e_rdy = rdy; v.e_busy = bz; v.e_err = er;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive_idle();
        issue_valid = 1'b0; issue_src1 = '0; issue_src2 = '0;
        issue_src1_used = 1'b0; issue_src2_used = 1'b0;
        issue_dst = '0; issue_dst_used = 1'b0;
        wb_valid = 1'b0; wb_addr = '0; flush = 1'b0;
    endtask

    // Drive at negedge, check ready mid-cycle, compare registered state after the edge.
    task automatic apply(input int id, input vec_t v);
        exp_t e;
        @(negedge clk);
        issue_valid = v.iv; issue_src1 = v.s1; issue_src1_used = v.s1u;
        issue_src2 = v.s2;  issue_src2_used = v.s2u;
        issue_dst = v.dst;  issue_dst_used = v.du;
        wb_valid = v.wbv;   wb_addr = v.wba; flush = v.fl;
        e.id = id; e.busy = v.e_busy; e.err = v.e_err;
        sb_q.push_back(e);
        #1;
        check($sformatf("vec%0d issue_ready", id), 16'(issue_ready), 16'(v.e_rdy));
        @(posedge clk);
        #1;
        e = sb_q.pop_front();
        check($sformatf("vec%0d busy_mask", e.id), 16'(busy_mask), 16'(e.busy));
        check($sformatf("vec%0d wb_err", e.id), 16'(wb_err), 16'(e.err));
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held, then released for five idle cycles.
        drive_idle();
        #12;
        check("reset busy_mask", 16'(busy_mask), 16'h0);
        check("reset issue_ready", 16'(issue_ready), 16'h1);
        check("reset wb_err", 16'(wb_err), 16'h0);
        @(negedge clk);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle busy_mask", 16'(busy_mask), 16'h0);
        check("idle issue_ready", 16'(issue_ready), 16'h1);
        check("idle wb_err", 16'(wb_err), 16'h0);

        //              iv s1 u  s2 u  dst u wb wa fl  rdy busy  err
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 0,  1, 8'h00, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 3,1, 0,0, 0,  1, 8'h08, 0));
        vecs.push_back(mk(1, 3,1, 0,0, 0,0, 0,0, 0,  0, 8'h08, 0));
        vecs.push_back(mk(1, 3,1, 0,0, 0,0, 1,3, 0,  0, 8'h00, 0));
        vecs.push_back(mk(1, 3,1, 0,0, 0,0, 0,0, 0,  1, 8'h00, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 0,  1, 8'h20, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 0,  1, 8'h20, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 0,  1, 8'h20, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 0,  0, 8'h20, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 6,1, 0,0, 0,  1, 8'h60, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 5,1, 1,5, 0,  0, 8'h60, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 5,1, 0,0, 0,  1, 8'h60, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 2,1, 0,0, 0,  1, 8'h64, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 2,1, 1,2, 0,  1, 8'h64, 0));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1,2, 0,  1, 8'h60, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 1,1, 0,0, 0,  1, 8'h62, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 4,1, 0,0, 0,  1, 8'h72, 0));
        vecs.push_back(mk(1, 0,0, 0,0, 0,1, 1,0, 1,  1, 8'h00, 0));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1,4, 0,  1, 8'h00, 1));
        vecs.push_back(mk(1, 0,0, 0,0, 7,1, 0,0, 0,  1, 8'h80, 1));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 0,0, 1,  1, 8'h00, 1));
        vecs.push_back(mk(1, 0,0, 0,0, 7,1, 0,0, 0,  1, 8'h80, 1));
        vecs.push_back(mk(1, 0,1, 7,1, 0,0, 0,0, 0,  0, 8'h80, 1));
        vecs.push_back(mk(1, 7,0, 7,0, 7,0, 0,0, 0,  1, 8'h80, 1));
        vecs.push_back(mk(0, 0,0, 0,0, 0,0, 1,7, 0,  1, 8'h00, 1));

        foreach (vecs[i]) apply(i, vecs[i]);

        // Asynchronous reset between clock edges clears busy and the sticky error.
        @(negedge clk);
        issue_valid = 1'b1; issue_dst = 3'd3; issue_dst_used = 1'b1;
        @(posedge clk);
        #1;
        check("pre-reset busy_mask", 16'(busy_mask), 16'h08);
        drive_idle();
        #2;
        rst = 1'b0;
        #1;
        check("async reset busy_mask", 16'(busy_mask), 16'h0);
        check("async reset wb_err", 16'(wb_err), 16'h0);
        check("async reset issue_ready", 16'(issue_ready), 16'h1);
        @(negedge clk);
        rst = 1'b1;

`ifdef REG_SCOREBOARD_STATS_EN
        @(negedge clk);
        issue_valid = 1'b1; issue_dst = 3'd7; issue_dst_used = 1'b1;
        @(negedge clk);
        issue_dst_used = 1'b0; issue_src1 = 3'd7; issue_src1_used = 1'b1;
        repeat (10) @(negedge clk);
        drive_idle();
        @(negedge clk);
        check("stall_cnt after 10 stalls", stall_cnt, 16'd10);
`endif

        drive_idle();
        @(negedge clk);
        if (sb_q.size() != 0) check("scoreboard drained", 16'(sb_q.size()), 16'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_reg_scoreboard
